uart_burst_seq: RTL

Parametrised UART byte-burst sequencer for the Lab1 AES bring-up datapath. It generates a burst of bytes (counter, fixed or LFSR pattern) and pushes them into `uart_wrapper` through its `I_TX_DATA` / `I_TX_START` / `O_BUSY` handshake. Pacing follows the busy handshake plus a programmable inter-byte gap, not fixed delays. It replaces hand-timed start pulses and free-running counters as the plaintext/key source when loading the AES core over UART.

---
 rtl/uart_burst_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_burst_seq.sv
// uart_burst_seq: generates counter/fixed/LFSR byte bursts into uart_wrapper via start/busy.
// Define UART_SEQ_CHECKSUM_EN to append an XOR checksum byte after the payload.
module uart_burst_seq #(
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned GAP_CYCLES   = 10000,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       CPU_RESET,
    input  logic       I_START,
    input  logic       I_ABORT,
    input  logic [1:0] I_MODE,
    input  logic [7:0] I_SEED,
    input  logic [7:0] I_LEN,
    input  logic       I_BUSY,
    output logic [7:0] O_TX_DATA,
    output logic       O_TX_START,
    output logic       O_ACTIVE,
    output logic       O_DONE,
    output logic       O_ERR,
    output logic [7:0] O_BYTE_CNT
);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle, StLoad, StFire, StWaitHi, StWaitLo, StGap, StNext, StDone
    } state_e;

    state_e          r_state;
    logic [1:0]      r_mode;
    logic [7:0]      r_seed;
    logic [7:0]      r_len;
    logic [7:0]      r_to_cnt;
    logic [GapW-1:0] r_gap_cnt;
    logic [7:0]      r_tx_data;
    logic            r_tx_start;
    logic            r_active;
    logic            r_done;
    logic            r_err;
    logic [7:0]      r_byte_cnt;
`ifdef UART_SEQ_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    logic [7:0] w_first;
    logic [7:0] w_next;
    logic [8:0] w_total;
    logic       w_last;

    assign w_first = (r_mode == 2'd2 && r_seed == 8'h00) ? 8'h01 : r_seed;

`ifdef UART_SEQ_CHECKSUM_EN
    assign w_total = {1'b0, r_len} + 9'd1;
`else
    assign w_total = {1'b0, r_len};
`endif
    assign w_last = ({1'b0, r_byte_cnt} + 9'd1) == w_total;

    always_comb begin
        case (r_mode)
            2'd1:    w_next = r_tx_data;
            // x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0
            2'd2:    w_next = {r_tx_data[6:0],
                               r_tx_data[7] ^ r_tx_data[5] ^ r_tx_data[4] ^ r_tx_data[3]};
            default: w_next = r_tx_data + 8'd1;
        endcase
`ifdef UART_SEQ_CHECKSUM_EN
        if (r_byte_cnt == r_len) begin
            w_next = r_csum;
        end
`endif
    end

    always_ff @(posedge CLK or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            r_state    <= StIdle;
            r_mode     <= 2'd0;
            r_seed     <= 8'h00;
            r_len      <= 8'h00;
            r_to_cnt   <= 8'h00;
            r_gap_cnt  <= '0;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_byte_cnt <= 8'h00;
`ifdef UART_SEQ_CHECKSUM_EN
            r_csum     <= 8'h00;
`endif
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            if (I_ABORT && r_state != StIdle) begin
                r_state  <= StIdle;
                r_active <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (I_START && !I_ABORT) begin
                            r_mode     <= I_MODE;
                            r_seed     <= I_SEED;
                            r_len      <= (I_LEN == 8'h00) ? 8'(BURST_LEN) : I_LEN;
                            r_err      <= 1'b0;
                            r_byte_cnt <= 8'h00;
                            r_active   <= 1'b1;
`ifdef UART_SEQ_CHECKSUM_EN
                            r_csum     <= 8'h00;
`endif
                            r_state    <= StLoad;
                        end
                    end
                    StLoad: begin
                        r_tx_data <= w_first;
                        r_state   <= StFire;
                    end
                    StFire: begin
                        r_tx_start <= 1'b1;
                        r_to_cnt   <= 8'h00;
                        r_state    <= StWaitHi;
                    end
                    StWaitHi: begin
                        if (I_BUSY) begin
                            r_state <= StWaitLo;
                        end else if (r_to_cnt == 8'(BUSY_TIMEOUT)) begin
                            r_err    <= 1'b1;
                            r_done   <= 1'b1;
                            r_active <= 1'b0;
                            r_state  <= StIdle;
                        end else begin
                            r_to_cnt <= r_to_cnt + 8'd1;
                        end
                    end
                    StWaitLo: begin
                        if (!I_BUSY) begin
                            r_byte_cnt <= r_byte_cnt + 8'd1;
`ifdef UART_SEQ_CHECKSUM_EN
                            if (!w_last) begin
                                r_csum <= r_csum ^ r_tx_data;
                            end
`endif
                            if (w_last) begin
                                r_state <= StDone;
                            end else if (GAP_CYCLES == 0) begin
                                r_state <= StNext;
                            end else begin
                                r_gap_cnt <= GapW'(GAP_CYCLES - 1);
                                r_state   <= StGap;
                            end
                        end
                    end
                    StGap: begin
                        if (r_gap_cnt == '0) begin
                            r_state <= StNext;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - 1'b1;
                        end
                    end
                    StNext: begin
                        r_tx_data <= w_next;
                        r_state   <= StFire;
                    end
                    StDone: begin
                        r_done   <= 1'b1;
                        r_active <= 1'b0;
                        r_state  <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign O_TX_DATA  = r_tx_data;
    assign O_TX_START = r_tx_start;
    assign O_ACTIVE   = r_active;
    assign O_DONE     = r_done;
    assign O_ERR      = r_err;
    assign O_BYTE_CNT = r_byte_cnt;

endmodule
